// File: rtl/uart_rx_pkg.sv
// Shared definitions for the IO-bus UART receiver: FSM encoding, status
// register layout and the default word-address decode bits.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rxState_t;

    localparam int ST_NONEMPTY = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_OVR      = 2;
    localparam int ST_FERR     = 3;
    localparam int ST_CNT_LSB  = 8;

    localparam int DEFAULT_DATA_BIT = 3;
    localparam int DEFAULT_STAT_BIT = 4;

    function automatic logic [31:0] statusWord(input logic       nonEmpty,
                                               input logic       full,
                                               input logic       ovr,
                                               input logic       ferr,
                                               input logic [7:0] count);
        logic [31:0] w;
        w                    = 32'd0;
        w[ST_NONEMPTY]       = nonEmpty;
        w[ST_FULL]           = full;
        w[ST_OVR]            = ovr;
        w[ST_FERR]           = ferr;
        w[ST_CNT_LSB +: 8]   = count;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_io_fifo.sv
// Small synchronous FIFO; a push into a full FIFO only lands when a pop
// happens in the same cycle, and a pop of an empty FIFO is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wData,
    output logic [WIDTH-1:0]         rData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]  wrPtr_r;
    logic [AW-1:0]  rdPtr_r;
    logic [AW:0]    count_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic           doPush_s;
    logic           doPop_s;

    assign full     = (count_r == (AW+1)'(DEPTH));
    assign empty    = (count_r == (AW+1)'(0));
    assign count    = count_r;
    assign rData    = mem_r[rdPtr_r];
    assign doPop_s  = pop && !empty;
    assign doPush_s = push && (!full || pop);

    // Storage array, intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (doPush_s) begin
            mem_r[wrPtr_r] <= wData;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_r <= AW'(0);
            rdPtr_r <= AW'(0);
            count_r <= (AW+1)'(0);
        end else begin
            if (doPush_s) begin
                wrPtr_r <= wrPtr_r + AW'(1);
            end
            if (doPop_s) begin
                rdPtr_r <= rdPtr_r + AW'(1);
            end
            case ({doPush_s, doPop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_io.sv
// Memory-mapped UART receiver (8N1): synchronizer, mid-bit sampling FSM,
// byte FIFO, and data/status registers on the one-hot IO word decode.
module uart_rx_io
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 8,
    parameter int DATA_BIT     = DEFAULT_DATA_BIT,
    parameter int STAT_BIT     = DEFAULT_STAT_BIT
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rxd_i,
    input  logic [13:0] IO_wordAddr_i,
    input  logic        IO_memRd_i,
    input  logic        IO_memWr_i,
    input  logic [31:0] IO_memWData_i,
    output logic [31:0] IO_memRData_o,
    output logic        rxAvail_o
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sync1_r, rxs_r, armed_r;
    rxState_t      state_r, nextState_s;
    logic [BW-1:0] baudCnt_r, nextCnt_s;
    logic [2:0]    bitCnt_r, nextBitCnt_s;
    logic [7:0]    shift_r, nextShift_s;
    logic          push_s, ferrSet_s;
    logic          overrun_r, frameErr_r;
    logic          selData_s, selStat_s, popReq_s, statWr_s, ovrSet_s;
    logic          fifoFull_s, fifoEmpty_s;
    logic [7:0]    fifoHead_s;
    logic [CW-1:0] fifoCount_s;
    logic [31:0]   dataWord_s, statWord_s;
    logic          unusedIo_s;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
        end else begin
            sync1_r <= rxd_i;
            rxs_r   <= sync1_r;
        end
    end

    // Receive FSM state; armed only after seeing the line high in IDLE,
    // so a held-low break cannot retrigger a frame.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r   <= IDLE;
            baudCnt_r <= BW'(0);
            bitCnt_r  <= 3'd0;
            shift_r   <= 8'd0;
            armed_r   <= 1'b0;
        end else begin
            state_r   <= nextState_s;
            baudCnt_r <= nextCnt_s;
            bitCnt_r  <= nextBitCnt_s;
            shift_r   <= nextShift_s;
            armed_r   <= (state_r == IDLE) ? rxs_r : 1'b0;
        end
    end

    // Next-state logic with mid-bit sampling at baud counter zero.
    always_comb begin
        nextState_s  = state_r;
        nextCnt_s    = baudCnt_r;
        nextBitCnt_s = bitCnt_r;
        nextShift_s  = shift_r;
        push_s       = 1'b0;
        ferrSet_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (armed_r && !rxs_r) begin
                    nextState_s = START;
                    nextCnt_s   = BW'(CLKS_PER_BIT / 2 - 1);
                end else begin
                    nextState_s = IDLE;
                end
            end
            START: begin
                if (baudCnt_r != BW'(0)) begin
                    nextCnt_s = baudCnt_r - BW'(1);
                end else if (rxs_r) begin
                    nextState_s = IDLE;
                end else begin
                    nextState_s  = DATA;
                    nextBitCnt_s = 3'd0;
                    nextCnt_s    = BW'(CLKS_PER_BIT - 1);
                end
            end
            DATA: begin
                if (baudCnt_r != BW'(0)) begin
                    nextCnt_s = baudCnt_r - BW'(1);
                end else begin
                    nextShift_s  = {rxs_r, shift_r[7:1]};
                    nextCnt_s    = BW'(CLKS_PER_BIT - 1);
                    nextBitCnt_s = bitCnt_r + 3'd1;
                    if (bitCnt_r == 3'd7) begin
                        nextState_s = STOP;
                    end else begin
                        nextState_s = DATA;
                    end
                end
            end
            STOP: begin
                if (baudCnt_r != BW'(0)) begin
                    nextCnt_s = baudCnt_r - BW'(1);
                end else begin
                    nextState_s = IDLE;
                    push_s      = rxs_r;
                    ferrSet_s   = !rxs_r;
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    assign selData_s = IO_wordAddr_i[DATA_BIT];
    assign selStat_s = IO_wordAddr_i[STAT_BIT];
    assign popReq_s  = IO_memRd_i && selData_s;
    assign statWr_s  = IO_memWr_i && selStat_s;
    assign ovrSet_s  = push_s && fifoFull_s && !popReq_s;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (reset_i),
        .push  (push_s),
        .pop   (popReq_s),
        .wData (shift_r),
        .rData (fifoHead_s),
        .full  (fifoFull_s),
        .empty (fifoEmpty_s),
        .count (fifoCount_s)
    );

    // Sticky error flags; a new event outranks a same-cycle clear.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            overrun_r   <= 1'b0;
            frameErr_r  <= 1'b0;
        end else begin
            if (ovrSet_s) begin
                overrun_r <= 1'b1;
            end else if (statWr_s && IO_memWData_i[ST_OVR]) begin
                overrun_r <= 1'b0;
            end
            if (ferrSet_s) begin
                frameErr_r <= 1'b1;
            end else if (statWr_s && IO_memWData_i[ST_FERR]) begin
                frameErr_r <= 1'b0;
            end
        end
    end

    // Read mux: selected registers are ORed so the SOC can OR this in too.
    always_comb begin
        statWord_s = statusWord(!fifoEmpty_s, fifoFull_s, overrun_r, frameErr_r, 8'(fifoCount_s));
        if (fifoEmpty_s) begin
            dataWord_s = 32'd0;
        end else begin
            dataWord_s = {23'd0, 1'b1, fifoHead_s};
        end
        IO_memRData_o = (selData_s ? dataWord_s : 32'd0) | (selStat_s ? statWord_s : 32'd0);
    end

    assign rxAvail_o  = !fifoEmpty_s;
    assign unusedIo_s = ^{IO_memWData_i, IO_wordAddr_i};

endmodule

// File: tb/tb_uart_rx_io.sv
// Directed bench for uart_rx_io at 16 clocks per bit: a vector table of
// single frames plus sequences for latency, false start, overrun and reset.
module tb_uart_rx_io;

    localparam int CPB = 16;
    localparam logic [13:0] A_DATA = 14'h0008;
    localparam logic [13:0] A_STAT = 14'h0010;
    localparam logic [13:0] A_BOTH = 14'h0018;
    localparam logic [13:0] A_NONE = 14'h0001;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        rxd_i;
    logic [13:0] IO_wordAddr_i;
    logic        IO_memRd_i;
    logic        IO_memWr_i;
    logic [31:0] IO_memWData_i;
    logic [31:0] IO_memRData_o;
    logic        rxAvail_o;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [7:0]  b;
        logic        stopBit;
        logic [31:0] expStat;
        logic [31:0] expData;
        logic [31:0] expAfter;
    } vec_t;

    vec_t vecs[6];

    uart_rx_io #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (8),
        .DATA_BIT     (3),
        .STAT_BIT     (4)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .rxd_i         (rxd_i),
        .IO_wordAddr_i (IO_wordAddr_i),
        .IO_memRd_i    (IO_memRd_i),
        .IO_memWr_i    (IO_memWr_i),
        .IO_memWData_i (IO_memWData_i),
        .IO_memRData_o (IO_memRData_o),
        .rxAvail_o     (rxAvail_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sendFrame(input logic [7:0] b, input logic stopBit);
        rxd_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_i = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd_i = stopBit;
        repeat (CPB) @(negedge clk);
        rxd_i = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic ioRead(input logic [13:0] addr, input logic strobe, output logic [31:0] val);
        @(negedge clk);
        IO_wordAddr_i = addr;
        IO_memRd_i    = strobe;
        #1 val = IO_memRData_o;
        @(negedge clk);
        IO_memRd_i    = 1'b0;
        IO_wordAddr_i = 14'd0;
    endtask

    task automatic ioWrite(input logic [13:0] addr, input logic [31:0] data);
        @(negedge clk);
        IO_wordAddr_i = addr;
        IO_memWr_i    = 1'b1;
        IO_memWData_i = data;
        @(negedge clk);
        IO_memWr_i    = 1'b0;
        IO_wordAddr_i = 14'd0;
        IO_memWData_i = 32'd0;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] head;
        int          cyc;

        vecs[0] = '{8'h55, 1'b1, 32'h101, 32'h155, 32'h000};
        vecs[1] = '{8'hA3, 1'b0, 32'h008, 32'h000, 32'h008};
        vecs[2] = '{8'h00, 1'b1, 32'h101, 32'h100, 32'h000};
        vecs[3] = '{8'hFF, 1'b1, 32'h101, 32'h1FF, 32'h000};
        vecs[4] = '{8'h80, 1'b1, 32'h101, 32'h180, 32'h000};
        vecs[5] = '{8'h01, 1'b1, 32'h101, 32'h101, 32'h000};

        reset_i       = 1'b0;
        rxd_i         = 1'b1;
        IO_wordAddr_i = A_BOTH;
        IO_memRd_i    = 1'b0;
        IO_memWr_i    = 1'b0;
        IO_memWData_i = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_rdata_both", IO_memRData_o, 32'h0);
        check("reset_rxavail", {31'd0, rxAvail_o}, 32'h0);
        IO_wordAddr_i = A_NONE;
        @(negedge clk);
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        #1 check("idle_rdata_nosel", IO_memRData_o, 32'h0);
        @(negedge clk);
        IO_wordAddr_i = 14'd0;

        // Latency of a 0x55 frame from the start edge to rxAvail_o.
        cyc = 0;
        fork
            sendFrame(8'h55, 1'b1);
            begin
                while (!rxAvail_o && cyc < 400) begin
                    @(negedge clk);
                    cyc++;
                end
            end
        join
        compared++;
        if (cyc < 150 || cyc > 158) begin
            mismatched++;
            $display("FAIL latency_0x55: got %0d cycles expected 150..158", cyc);
        end
        ioRead(A_DATA, 1'b1, r);
        check("lat_data", r, 32'h155);
        ioRead(A_STAT, 1'b0, r);
        check("lat_stat_after_pop", r, 32'h000);

        for (int v = 0; v < 6; v++) begin
            sendFrame(vecs[v].b, vecs[v].stopBit);
            ioRead(A_STAT, 1'b0, r);
            check($sformatf("vec%0d_stat", v), r, vecs[v].expStat);
            ioRead(A_DATA, 1'b1, r);
            check($sformatf("vec%0d_data", v), r, vecs[v].expData);
            ioRead(A_STAT, 1'b0, r);
            check($sformatf("vec%0d_after", v), r, vecs[v].expAfter);
            ioWrite(A_STAT, 32'hC);
            ioRead(A_STAT, 1'b0, r);
            check($sformatf("vec%0d_cleared", v), r, 32'h000);
        end

        // False start: short low glitch must not produce a byte.
        @(negedge clk);
        rxd_i = 1'b0;
        repeat (3) @(negedge clk);
        rxd_i = 1'b1;
        repeat (40) @(negedge clk);
        ioRead(A_STAT, 1'b0, r);
        check("false_start_stat", r, 32'h000);
        check("false_start_avail", {31'd0, rxAvail_o}, 32'h0);
        sendFrame(8'h3C, 1'b1);
        ioRead(A_DATA, 1'b1, r);
        check("after_false_start_data", r, 32'h13C);

        // Overrun: nine frames into an eight-entry FIFO.
        for (int i = 0; i < 9; i++) begin
            sendFrame(8'(i), 1'b1);
        end
        ioRead(A_STAT, 1'b0, r);
        check("ovr_stat", r, 32'h807);
        for (int i = 0; i < 8; i++) begin
            ioRead(A_DATA, 1'b1, r);
            check($sformatf("ovr_pop%0d", i), r, 32'h100 + 32'(i));
        end
        ioRead(A_STAT, 1'b0, r);
        check("ovr_stat_drained", r, 32'h004);
        ioWrite(A_STAT, 32'h4);
        ioRead(A_STAT, 1'b0, r);
        check("ovr_cleared", r, 32'h000);

        // Full FIFO: pop strobe lands on the same edge as the ninth push.
        for (int i = 0; i < 8; i++) begin
            sendFrame(8'h10 + 8'(i), 1'b1);
        end
        ioRead(A_STAT, 1'b0, r);
        check("full_stat", r, 32'h803);
        head = 32'd0;
        fork
            sendFrame(8'h18, 1'b1);
            begin
                repeat (154) @(negedge clk);
                IO_wordAddr_i = A_DATA;
                IO_memRd_i    = 1'b1;
                #1 head = IO_memRData_o;
                @(negedge clk);
                IO_memRd_i    = 1'b0;
                IO_wordAddr_i = 14'd0;
            end
        join
        check("simul_head", head, 32'h110);
        ioRead(A_STAT, 1'b0, r);
        check("simul_stat", r, 32'h803);
        for (int i = 1; i < 9; i++) begin
            ioRead(A_DATA, 1'b1, r);
            check($sformatf("simul_pop%0d", i), r, 32'h110 + 32'(i));
        end
        ioRead(A_STAT, 1'b0, r);
        check("simul_empty", r, 32'h000);

        // Asynchronous reset in the middle of a frame with three bytes queued.
        sendFrame(8'h31, 1'b1);
        sendFrame(8'h32, 1'b1);
        sendFrame(8'h33, 1'b1);
        ioRead(A_BOTH, 1'b0, r);
        check("both_selected", r, 32'h331);
        fork
            sendFrame(8'h77, 1'b1);
            begin
                repeat (60) @(negedge clk);
                IO_wordAddr_i = A_BOTH;
                #3 reset_i = 1'b0;
                #1;
                check("rst_mid_rdata", IO_memRData_o, 32'h0);
                check("rst_mid_avail", {31'd0, rxAvail_o}, 32'h0);
                IO_wordAddr_i = 14'd0;
            end
        join
        repeat (5) @(negedge clk);
        reset_i = 1'b1;
        repeat (5) @(negedge clk);
        ioRead(A_STAT, 1'b0, r);
        check("rst_stat", r, 32'h000);
        sendFrame(8'hC3, 1'b1);
        ioRead(A_DATA, 1'b1, r);
        check("rst_c3_data", r, 32'h1C3);
        ioRead(A_STAT, 1'b0, r);
        check("rst_c3_stat", r, 32'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
